pcie_ort: RTL and testbench



---
 rtl/pcie_ort_if.sv | 48 ++++
 rtl/pcie_ort.sv | 149 ++++++++++++++
 tb/tb_pcie_ort.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pcie_ort_if.sv
// rtl/pcie_ort_if.sv - Outstanding read table bus: allocation, completion lookup/update, status
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 16
`endif

interface pcie_ort_if #(
    parameter int MEM_ADDR_BITS = `MEM_ADDR_BITS
);
    logic                     ort_req_v;
    logic [3:0]               ort_req_tag;
    logic [1:0]               ort_req_iface;
    logic [3:0]               ort_req_mem;
    logic [MEM_ADDR_BITS-1:0] ort_req_addr;
    logic                     ort_next_tag_v;
    logic [3:0]               ort_next_tag;
    logic                     cpl_lookup_v;
    logic [3:0]               cpl_lookup_tag;
    logic                     cpl_rsp_v;
    logic                     cpl_rsp_hit;
    logic [1:0]               cpl_rsp_iface;
    logic [3:0]               cpl_rsp_mem;
    logic [MEM_ADDR_BITS-1:0] cpl_rsp_addr;
    logic                     cpl_upd_v;
    logic [3:0]               cpl_upd_tag;
    logic [9:0]               cpl_upd_dw;
    logic                     cpl_upd_last;
    logic                     ort_err;
    logic                     ort_timeout_v;
    logic [15:0]              ort_timeout_mask;

    modport master (
        output ort_req_v, ort_req_tag, ort_req_iface, ort_req_mem, ort_req_addr,
        input  ort_next_tag_v, ort_next_tag,
        output cpl_lookup_v, cpl_lookup_tag,
        input  cpl_rsp_v, cpl_rsp_hit, cpl_rsp_iface, cpl_rsp_mem, cpl_rsp_addr,
        output cpl_upd_v, cpl_upd_tag, cpl_upd_dw, cpl_upd_last,
        input  ort_err, ort_timeout_v, ort_timeout_mask
    );

    modport slave (
        input  ort_req_v, ort_req_tag, ort_req_iface, ort_req_mem, ort_req_addr,
        output ort_next_tag_v, ort_next_tag,
        input  cpl_lookup_v, cpl_lookup_tag,
        output cpl_rsp_v, cpl_rsp_hit, cpl_rsp_iface, cpl_rsp_mem, cpl_rsp_addr,
        input  cpl_upd_v, cpl_upd_tag, cpl_upd_dw, cpl_upd_last,
        output ort_err, ort_timeout_v, ort_timeout_mask
    );
endinterface

// File: rtl/pcie_ort.sv
// rtl/pcie_ort.sv - PCIe outstanding read table (optional completion timeout: PCIE_ORT_TIMEOUT_EN)
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 16
`endif

module pcie_ort #(
    parameter int MEM_ADDR_BITS  = `MEM_ADDR_BITS,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic      pcie_clk,
    input  logic      rst,
    pcie_ort_if.slave ort
);
    logic [15:0]              busy;
    logic [1:0]               ent_iface [16];
    logic [3:0]               ent_mem   [16];
    logic [MEM_ADDR_BITS-1:0] ent_addr  [16];

    logic [15:0]              pend;
    logic [3:0]               next_tag;
    logic                     rsp_v;
    logic                     rsp_hit;
    logic [1:0]               rsp_iface;
    logic [3:0]               rsp_mem;
    logic [MEM_ADDR_BITS-1:0] rsp_addr;
    logic                     err;
    logic [15:0]              expire;
    logic                     to_v;
    logic [15:0]              to_mask;

    logic                     upd_busy;
    logic                     free_same;
    logic                     alloc_clash;
    logic                     lkp_busy;
    logic [MEM_ADDR_BITS-1:0] upd_inc;

    if (TIMEOUT_CYCLES < 16 || (TIMEOUT_CYCLES & (TIMEOUT_CYCLES - 1)) != 0) begin : g_bad_timeout
        $error("pcie_ort: TIMEOUT_CYCLES must be a power of 2 and at least 16");
    end

    assign upd_busy    = busy[ort.cpl_upd_tag];
    assign lkp_busy    = busy[ort.cpl_lookup_tag];
    assign upd_inc     = MEM_ADDR_BITS'({ort.cpl_upd_dw, 2'b00});
    // A final completion on the same tag frees it before the new allocation lands.
    assign free_same   = ort.cpl_upd_v & ort.cpl_upd_last & upd_busy & (ort.cpl_upd_tag == ort.ort_req_tag);
    assign alloc_clash = ort.ort_req_v & busy[ort.ort_req_tag] & ~free_same & ~expire[ort.ort_req_tag];

    // Lowest free tag, treating an in-flight allocation as already taken.
    always_comb begin
        pend     = busy;
        next_tag = 4'd0;
        if (ort.ort_req_v) pend[ort.ort_req_tag] = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            if (!pend[i]) next_tag = 4'(i);
        end
    end

    // Table state: lookup (read-before-write), completion update/free, then allocation.
    always_ff @(posedge pcie_clk) begin
        if (rst) begin
            busy      <= '0;
            err       <= 1'b0;
            rsp_v     <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_iface <= '0;
            rsp_mem   <= '0;
            rsp_addr  <= '0;
        end else begin
            rsp_v <= ort.cpl_lookup_v;
            if (ort.cpl_lookup_v) begin
                rsp_hit   <= lkp_busy;
                rsp_iface <= lkp_busy ? ent_iface[ort.cpl_lookup_tag] : '0;
                rsp_mem   <= lkp_busy ? ent_mem[ort.cpl_lookup_tag]   : '0;
                rsp_addr  <= lkp_busy ? ent_addr[ort.cpl_lookup_tag]  : '0;
            end
            busy <= busy & ~expire;
            if (ort.cpl_upd_v) begin
                if (!upd_busy) begin
                    err <= 1'b1;
                end else begin
                    ent_addr[ort.cpl_upd_tag] <= ent_addr[ort.cpl_upd_tag] + upd_inc;
                    if (ort.cpl_upd_last) busy[ort.cpl_upd_tag] <= 1'b0;
                end
            end
            if (ort.ort_req_v) begin
                if (alloc_clash) err <= 1'b1;
                busy[ort.ort_req_tag]      <= 1'b1;
                ent_iface[ort.ort_req_tag] <= ort.ort_req_iface;
                ent_mem[ort.ort_req_tag]   <= ort.ort_req_mem;
                ent_addr[ort.ort_req_tag]  <= ort.ort_req_addr;
            end
        end
    end

`ifdef PCIE_ORT_TIMEOUT_EN
    localparam int PRE_W = $clog2(TIMEOUT_CYCLES / 4);

    logic [PRE_W-1:0] pre;
    logic             tick;
    logic [1:0]       age [16];

    assign tick = &pre;

    // A tag expires when it has aged through three ticks with no activity; a same-edge update rescues it.
    always_comb begin
        expire = '0;
        for (int i = 0; i < 16; i++) begin
            expire[i] = tick & busy[i] & (age[i] == 2'd3)
                        & ~(ort.cpl_upd_v & (ort.cpl_upd_tag == 4'(i)));
        end
    end

    // Prescaler, per-tag ages and the registered expiry report.
    always_ff @(posedge pcie_clk) begin
        if (rst) begin
            pre     <= '0;
            to_v    <= 1'b0;
            to_mask <= '0;
            for (int i = 0; i < 16; i++) age[i] <= 2'd0;
        end else begin
            pre     <= pre + 1'b1;
            to_v    <= |expire;
            to_mask <= expire;
            for (int i = 0; i < 16; i++) begin
                if ((ort.ort_req_v && ort.ort_req_tag == 4'(i)) ||
                    (ort.cpl_upd_v && ort.cpl_upd_tag == 4'(i)))
                    age[i] <= 2'd0;
                else if (tick && busy[i])
                    age[i] <= age[i] + 2'd1;
            end
        end
    end
`else
    assign expire  = '0;
    assign to_v    = 1'b0;
    assign to_mask = '0;
`endif

    assign ort.ort_next_tag_v   = ~&pend;
    assign ort.ort_next_tag     = next_tag;
    assign ort.cpl_rsp_v        = rsp_v;
    assign ort.cpl_rsp_hit      = rsp_hit;
    assign ort.cpl_rsp_iface    = rsp_iface;
    assign ort.cpl_rsp_mem      = rsp_mem;
    assign ort.cpl_rsp_addr     = rsp_addr;
    assign ort.ort_err          = err;
    assign ort.ort_timeout_v    = to_v;
    assign ort.ort_timeout_mask = to_mask;
endmodule

// File: tb/tb_pcie_ort.sv
// tb/tb_pcie_ort.sv - Directed self-checking bench for pcie_ort
module tb_pcie_ort;
    logic pcie_clk = 1'b0;
    logic rst      = 1'b1;
    int   n_chk    = 0;
    int   n_pass   = 0;

    always #5 pcie_clk = ~pcie_clk;

    pcie_ort_if #(.MEM_ADDR_BITS(16)) bus ();

    pcie_ort #(.MEM_ADDR_BITS(16), .TIMEOUT_CYCLES(64)) dut (
        .pcie_clk (pcie_clk),
        .rst      (rst),
        .ort      (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge pcie_clk);
        #1;
    endtask

    task automatic idle();
        bus.ort_req_v     = 1'b0;
        bus.ort_req_tag   = '0;
        bus.ort_req_iface = '0;
        bus.ort_req_mem   = '0;
        bus.ort_req_addr  = '0;
        bus.cpl_lookup_v  = 1'b0;
        bus.cpl_lookup_tag = '0;
        bus.cpl_upd_v     = 1'b0;
        bus.cpl_upd_tag   = '0;
        bus.cpl_upd_dw    = '0;
        bus.cpl_upd_last  = 1'b0;
    endtask

    task automatic set_alloc(input logic [3:0] t, input logic [1:0] ifc, input logic [3:0] m, input logic [15:0] a);
        bus.ort_req_v = 1'b1; bus.ort_req_tag = t; bus.ort_req_iface = ifc;
        bus.ort_req_mem = m; bus.ort_req_addr = a;
    endtask

    task automatic set_upd(input logic [3:0] t, input logic [9:0] dw, input logic last);
        bus.cpl_upd_v = 1'b1; bus.cpl_upd_tag = t; bus.cpl_upd_dw = dw; bus.cpl_upd_last = last;
    endtask

    task automatic alloc(input logic [3:0] t, input logic [1:0] ifc, input logic [3:0] m, input logic [15:0] a);
        set_alloc(t, ifc, m, a); step(); idle();
    endtask

    task automatic upd(input logic [3:0] t, input logic [9:0] dw, input logic last);
        set_upd(t, dw, last); step(); idle();
    endtask

    task automatic lookup(input logic [3:0] t);
        bus.cpl_lookup_v = 1'b1; bus.cpl_lookup_tag = t; step(); idle();
    endtask

    task automatic do_reset();
        rst = 1'b1; idle(); step(); step(); rst = 1'b0;
    endtask

    initial begin
        idle();
        do_reset();
        check("rst_next_v",   bus.ort_next_tag_v, 1);
        check("rst_next_tag", bus.ort_next_tag, 0);
        check("rst_rsp_v",    bus.cpl_rsp_v, 0);
        check("rst_err",      bus.ort_err, 0);
        check("rst_to_v",     bus.ort_timeout_v, 0);
        check("rst_to_mask",  bus.ort_timeout_mask, 0);

        // Allocate tag 0: the offered tag moves on in the same cycle.
        set_alloc(4'd0, 2'd2, 4'd5, 16'h1234);
        #1;
        check("inflight_next", bus.ort_next_tag, 1);
        step(); idle();
        lookup(4'd0);
        check("t0_rsp_v",  bus.cpl_rsp_v, 1);
        check("t0_hit",    bus.cpl_rsp_hit, 1);
        check("t0_iface",  bus.cpl_rsp_iface, 2);
        check("t0_mem",    bus.cpl_rsp_mem, 5);
        check("t0_addr",   bus.cpl_rsp_addr, 16'h1234);
        step();
        check("t0_rsp_pulse", bus.cpl_rsp_v, 0);

        // Address advance then free on last completion.
        alloc(4'd3, 2'd1, 4'd7, 16'h0100);
        upd(4'd3, 10'd16, 1'b0);
        lookup(4'd3);
        check("t3_hit",  bus.cpl_rsp_hit, 1);
        check("t3_addr", bus.cpl_rsp_addr, 16'h0140);
        upd(4'd3, 10'd8, 1'b1);
        lookup(4'd3);
        check("t3_miss",      bus.cpl_rsp_hit, 0);
        check("t3_miss_addr", bus.cpl_rsp_addr, 0);
        check("t3_miss_mem",  bus.cpl_rsp_mem, 0);
        check("after_free_next", bus.ort_next_tag, 1);

        // Fill the table.
        for (int t = 1; t < 16; t++) alloc(4'(t), 2'(t), 4'(t), 16'(t * 16));
        check("full_next_v",   bus.ort_next_tag_v, 0);
        check("full_next_tag", bus.ort_next_tag, 0);
        check("full_err",      bus.ort_err, 0);
        upd(4'd9, 10'd0, 1'b1);
        check("free9_next_v",   bus.ort_next_tag_v, 1);
        check("free9_next_tag", bus.ort_next_tag, 9);

        // Free and reallocate tag 5 in one cycle: no error, new contents.
        set_upd(4'd5, 10'd3, 1'b1);
        set_alloc(4'd5, 2'd3, 4'd12, 16'h5550);
        step(); idle();
        lookup(4'd5);
        check("t5_hit",  bus.cpl_rsp_hit, 1);
        check("t5_addr", bus.cpl_rsp_addr, 16'h5550);
        check("t5_mem",  bus.cpl_rsp_mem, 12);
        check("t5_err",  bus.ort_err, 0);
        alloc(4'd6, 2'd0, 4'd0, 16'h0600);
        check("t6_err", bus.ort_err, 1);
        step(); step();
        check("err_sticky", bus.ort_err, 1);

        // Address wrap and read-before-write on a same-cycle lookup/update.
        alloc(4'd9, 2'd0, 4'd1, 16'hFFF0);
        upd(4'd9, 10'd8, 1'b0);
        lookup(4'd9);
        check("wrap_addr", bus.cpl_rsp_addr, 16'h0010);
        bus.cpl_lookup_v = 1'b1; bus.cpl_lookup_tag = 4'd9;
        set_upd(4'd9, 10'd4, 1'b0);
        step(); idle();
        check("rbw_addr", bus.cpl_rsp_addr, 16'h0010);
        lookup(4'd9);
        check("rbw_after", bus.cpl_rsp_addr, 16'h0020);
        check("no_to_v", bus.ort_timeout_v, 0);

        // Reset mid-operation discards everything.
        do_reset();
        check("rst2_err",  bus.ort_err, 0);
        check("rst2_next", bus.ort_next_tag, 0);
        lookup(4'd0);
        check("rst2_miss", bus.cpl_rsp_hit, 0);

`ifdef PCIE_ORT_TIMEOUT_EN
        begin
            int  cyc;
            bit  seen;
            alloc(4'd2, 2'd1, 4'd1, 16'h2000);
            cyc = 1;
            seen = 0;
            while (!seen && cyc < 200) begin
                if (bus.ort_timeout_v) seen = 1;
                else begin step(); cyc++; end
            end
            check("to_seen", seen, 1);
            check("to_window", (cyc >= 48 && cyc <= 65), 1);
            check("to_mask", bus.ort_timeout_mask, 16'h0004);
            step();
            check("to_pulse", bus.ort_timeout_v, 0);
            lookup(4'd2);
            check("to_freed", bus.cpl_rsp_hit, 0);

            alloc(4'd2, 2'd1, 4'd1, 16'h2000);
            for (int i = 0; i < 30; i++) step();
            do_reset();
            seen = 0;
            for (int i = 0; i < 100; i++) begin
                if (bus.ort_timeout_v) seen = 1;
                step();
            end
            check("rst_no_to", seen, 0);
        end
`else
        for (int i = 0; i < 100; i++) step();
        check("off_to_v",    bus.ort_timeout_v, 0);
        check("off_to_mask", bus.ort_timeout_mask, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
